nios2system_cpu_cpu_debug_cmd_bridge: RTL and testbench

- Parametrised sysclk-side successor of the debug-slave command path.
- Takes a JTAG-domain update toggle plus quasi-static IR/DR contents and synchronises them into clk.
- Buffers captured commands in a FIFO and presents them on a valid/ready handshake.
- On pop, decodes per-instruction take_action / take_no_action strobes for any IR width.
- Sits between the virtual-JTAG TCK logic and the OCI break/ocimem/trace controllers.

---
 rtl/nios2system_cpu_cpu_debug_cmd_bridge_if.sv | 27 ++
 rtl/nios2system_cpu_cpu_debug_cmd_bridge.sv | 122 ++++++++++++
 tb/tb_nios2system_cpu_cpu_debug_cmd_bridge.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/nios2system_cpu_cpu_debug_cmd_bridge_if.sv
// Command-side bus of the debug command bridge: FIFO head, handshake and decoded strobes.
// The bridge drives the master modport; the OCI consumer uses the slave modport.
interface nios2system_cpu_cpu_debug_cmd_bridge_if #(
    parameter int DR_W = 38,
    parameter int IR_W = 2
);
    localparam int NUM_IR = 2 ** IR_W;

    // Handshake: an entry transfers on every clk edge where cmd_valid && cmd_ready.
    // cmd_valid never depends on cmd_ready, and jdo/cmd_ir hold steady while cmd_valid waits.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DR_W-1:0]   jdo;
    logic [IR_W-1:0]   cmd_ir;
    logic [NUM_IR-1:0] take_action;
    logic [NUM_IR-1:0] take_no_action;

    modport master (
        output cmd_valid, jdo, cmd_ir, take_action, take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, jdo, cmd_ir, take_action, take_no_action,
        output cmd_ready
    );
endinterface

// File: rtl/nios2system_cpu_cpu_debug_cmd_bridge.sv
// Syncs JTAG update-DR toggles into clk, queues {ir_in, sr} in a FWFT FIFO and decodes pop strobes.
// Optional NIOS2SYSTEM_DEBUG_CMD_PARITY_EN: drop commands with odd parity and flag parity_err.
module nios2system_cpu_cpu_debug_cmd_bridge #(
    parameter int DR_W        = 38,
    parameter int IR_W        = 2,
    parameter int ACT_BIT     = 35,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               upd_toggle,
    input  logic [IR_W-1:0]                    ir_in,
    input  logic [DR_W-1:0]                    sr,
    input  logic                               clr_overflow,
    nios2system_cpu_cpu_debug_cmd_bridge_if.master cmd,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
`ifdef NIOS2SYSTEM_DEBUG_CMD_PARITY_EN
    output logic                               parity_err,
`endif
    output logic                               overflow
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int EW    = IR_W + DR_W;
    localparam int ARM_N = SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [2:0]             arm_cnt_q, arm_cnt_d;
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [EW-1:0]          mem_d [FIFO_DEPTH];
    logic                   overflow_q, overflow_d;

    logic          sync_out, armed, detect, push_req, push, pop, full, empty;
    logic [PW-1:0] level;
    logic [EW-1:0] head;

`ifdef NIOS2SYSTEM_DEBUG_CMD_PARITY_EN
    logic parity_err_q, parity_err_d;
    logic par_bad;
`endif

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], upd_toggle};
        sync_out = sync_q[SYNC_STAGES-1];
        // History always follows the synchroniser, so a toggle parked at 1 over reset is absorbed while unarmed.
        hist_d    = sync_out;
        armed     = (arm_cnt_q == 3'(ARM_N));
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
        detect    = (sync_out ^ hist_q) & armed;

`ifdef NIOS2SYSTEM_DEBUG_CMD_PARITY_EN
        par_bad      = ^sr;
        push_req     = detect & ~par_bad;
        parity_err_d = (detect & par_bad) | (parity_err_q & ~clr_overflow);
`else
        push_req     = detect;
`endif

        level = wptr_q - rptr_q;
        empty = (wptr_q == rptr_q);
        full  = (level == PW'(FIFO_DEPTH));
        pop   = ~empty & cmd.cmd_ready;
        // When full, a push only fits if the head leaves in the same cycle.
        push  = push_req & (~full | pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = {ir_in, sr};
        end
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);

        overflow_d = (push_req & full & ~pop) | (overflow_q & ~clr_overflow);

        head               = mem_q[rptr_q[AW-1:0]];
        cmd.cmd_valid      = ~empty;
        cmd.jdo            = head[DR_W-1:0];
        cmd.cmd_ir         = head[EW-1:DR_W];
        cmd.take_action    = '0;
        cmd.take_no_action = '0;
        if (pop) begin
            if (head[ACT_BIT]) cmd.take_action[head[EW-1:DR_W]]    = 1'b1;
            else               cmd.take_no_action[head[EW-1:DR_W]] = 1'b1;
        end
        fifo_level = level;
        overflow   = overflow_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            hist_q     <= 1'b0;
            arm_cnt_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            arm_cnt_q  <= arm_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

`ifdef NIOS2SYSTEM_DEBUG_CMD_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) parity_err_q <= 1'b0;
        else          parity_err_q <= parity_err_d;
    end
    assign parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_nios2system_cpu_cpu_debug_cmd_bridge.sv
// Directed bench for the debug command bridge: arming, latency, decode, fill/overflow, full+pop, reset.
module tb_nios2system_cpu_cpu_debug_cmd_bridge;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        upd_toggle = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic        clr_overflow = 1'b0;
    logic [2:0]  fifo_level;
    logic        overflow;
`ifdef NIOS2SYSTEM_DEBUG_CMD_PARITY_EN
    logic        parity_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [37:0] f_sr [6];
    logic [1:0]  f_ir [6];

    nios2system_cpu_cpu_debug_cmd_bridge_if #(.DR_W(38), .IR_W(2)) bif ();

    nios2system_cpu_cpu_debug_cmd_bridge dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .upd_toggle   (upd_toggle),
        .ir_in        (ir_in),
        .sr           (sr),
        .clr_overflow (clr_overflow),
        .cmd          (bif.master),
        .fifo_level   (fifo_level),
`ifdef NIOS2SYSTEM_DEBUG_CMD_PARITY_EN
        .parity_err   (parity_err),
`endif
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] pfix(input logic [37:0] v);
        logic [37:0] r;
        r = v;
`ifdef NIOS2SYSTEM_DEBUG_CMD_PARITY_EN
        r[37] = ^v[36:0];
`endif
        return r;
    endfunction

    task automatic send(input logic [1:0] ir, input logic [37:0] d);
        ir_in      = ir;
        sr         = d;
        upd_toggle = ~upd_toggle;
    endtask

    // Head must match (ir, d); strobes expected only when the head is being popped.
    task automatic chk_head(input string tag, input logic [1:0] ir, input logic [37:0] d, input logic popping);
        logic [3:0] onehot;
        onehot = 4'b0001 << ir;
        chk({tag, ".valid"}, 64'(bif.cmd_valid), 64'd1);
        chk({tag, ".jdo"},   64'(bif.jdo),       64'(d));
        chk({tag, ".ir"},    64'(bif.cmd_ir),    64'(ir));
        chk({tag, ".act"},   64'(bif.take_action),    (popping && d[35])  ? 64'(onehot) : 64'd0);
        chk({tag, ".noact"}, 64'(bif.take_no_action), (popping && !d[35]) ? 64'(onehot) : 64'd0);
    endtask

    task automatic do_reset(input logic tog);
        reset_n    = 1'b0;
        upd_toggle = tog;
        bif.cmd_ready = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            f_ir[i] = 2'(i);
            f_sr[i] = pfix((i % 2 == 1) ? (38'h08_0000_0000 | 38'(i)) : (38'h00_0000_1000 | 38'(i)));
        end
        bif.cmd_ready = 1'b0;

        // Reset values, with upd_toggle held high through reset
        upd_toggle = 1'b1;
        repeat (2) tick();
        chk("rst.valid", 64'(bif.cmd_valid), 64'd0);
        chk("rst.jdo",   64'(bif.jdo), 64'd0);
        chk("rst.ir",    64'(bif.cmd_ir), 64'd0);
        chk("rst.act",   64'(bif.take_action), 64'd0);
        chk("rst.noact", 64'(bif.take_no_action), 64'd0);
        chk("rst.level", 64'(fifo_level), 64'd0);
        chk("rst.ovf",   64'(overflow), 64'd0);
`ifdef NIOS2SYSTEM_DEBUG_CMD_PARITY_EN
        chk("rst.perr",  64'(parity_err), 64'd0);
`endif
        reset_n = 1'b1;
        repeat (10) tick();
        chk("arm.valid", 64'(bif.cmd_valid), 64'd0);
        chk("arm.level", 64'(fifo_level), 64'd0);

        // Single command, take_action decode, 3-edge latency
        do_reset(1'b0);
        bif.cmd_ready = 1'b1;
        send(2'b01, 38'h08_1234_5678);
        tick();
        chk("lat.e1", 64'(bif.cmd_valid), 64'd0);
        tick();
        chk("lat.e2", 64'(bif.cmd_valid), 64'd0);
        tick();
        chk_head("single", 2'b01, 38'h08_1234_5678, 1'b1);
        chk("single.actval", 64'(bif.take_action), 64'h2);
        tick();
        chk("single.gone", 64'(bif.cmd_valid), 64'd0);
        chk("single.act0", 64'(bif.take_action), 64'd0);

        // No-action decode
        send(2'b11, pfix(38'h00_0000_00A5));
        repeat (3) tick();
        chk_head("noact", 2'b11, pfix(38'h00_0000_00A5), 1'b1);
        chk("noact.val", 64'(bif.take_no_action), 64'h8);
        tick();
        chk("noact.gone", 64'(bif.cmd_valid), 64'd0);

        // Fill to four, fifth overflows
        bif.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(f_ir[i], f_sr[i]);
            repeat (6) tick();
            chk($sformatf("fill%0d.level", i), 64'(fifo_level), (i < 4) ? 64'(i + 1) : 64'd4);
            chk($sformatf("fill%0d.ovf", i), 64'(overflow), (i == 4) ? 64'd1 : 64'd0);
        end
        chk_head("fill.head", f_ir[0], f_sr[0], 1'b0);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("clr.ovf",   64'(overflow), 64'd0);
        chk("clr.level", 64'(fifo_level), 64'd4);

        // Push arriving while full, in the same cycle as a pop
        send(f_ir[5], f_sr[5]);
        repeat (2) tick();
        bif.cmd_ready = 1'b1;
        #1;
        chk_head("fullpop", f_ir[0], f_sr[0], 1'b1);
        tick();
        bif.cmd_ready = 1'b0;
        #1;
        chk("fullpop.level", 64'(fifo_level), 64'd4);
        chk("fullpop.ovf",   64'(overflow), 64'd0);
        chk_head("fullpop.head", f_ir[1], f_sr[1], 1'b0);
        bif.cmd_ready = 1'b1;
        #1;
        chk_head("drain1", f_ir[1], f_sr[1], 1'b1);
        tick();
        chk_head("drain2", f_ir[2], f_sr[2], 1'b1);
        tick();
        chk_head("drain3", f_ir[3], f_sr[3], 1'b1);
        tick();
        chk_head("drain5", f_ir[5], f_sr[5], 1'b1);
        tick();
        chk("drain.valid", 64'(bif.cmd_valid), 64'd0);
        chk("drain.level", 64'(fifo_level), 64'd0);
        bif.cmd_ready = 1'b0;

        // Reset mid-operation discards the buffered command
        send(2'b10, pfix(38'h3));
        repeat (6) tick();
        chk("mid.level1", 64'(fifo_level), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid.rst.level", 64'(fifo_level), 64'd0);
        chk("mid.rst.valid", 64'(bif.cmd_valid), 64'd0);
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("mid.rearm.level", 64'(fifo_level), 64'd0);

`ifdef NIOS2SYSTEM_DEBUG_CMD_PARITY_EN
        send(2'b01, 38'h1);
        repeat (6) tick();
        chk("par.bad.level", 64'(fifo_level), 64'd0);
        chk("par.bad.err",   64'(parity_err), 64'd1);
        send(2'b01, pfix(38'h1));
        repeat (6) tick();
        chk("par.good.level", 64'(fifo_level), 64'd1);
        chk("par.good.err",   64'(parity_err), 64'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("par.clr", 64'(parity_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
